// File: rtl/tlc_pkg.sv
// Shared constants and types for the lamp-side monitor of the traffic light
// controller: per-road light codes, fault codes and the monitor state.
package tlc_pkg;

   localparam logic [2:0]  RED     = 3'b100;
   localparam logic [2:0]  YEL     = 3'b010;
   localparam logic [2:0]  GRN     = 3'b001;
   localparam logic [11:0] ALL_RED = 12'b100100100100;

   typedef enum logic [1:0] {
      NONE     = 2'd0,
      CONFLICT = 2'd1,
      ILLEGAL  = 2'd2,
      SKIP     = 2'd3
   } fault_code_t;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      STRETCH = 2'd1,
      FLASH   = 2'd2
   } mon_state_t;

   // True when two or more roads are active at once.
   function automatic logic multi_active(input logic [3:0] act);
      return (act & (act - 4'd1)) != 4'd0;
   endfunction

endpackage

// File: rtl/tlc_lamp_monitor_if.sv
// Light-code bus from the controller plus lamp/fault outputs of the monitor.
// No handshake: id is sampled on every rising clock edge, outputs are registered.
interface tlc_lamp_monitor_if;
   import tlc_pkg::*;

   logic [11:0] id;
   logic [3:0]  lamp_red;
   logic [3:0]  lamp_yel;
   logic [3:0]  lamp_grn;
   logic        fault;
   logic [1:0]  fault_code;
   logic [3:0]  cam_arm;
   mon_state_t  state_dbg;

   modport master (
      output id,
      input  lamp_red, lamp_yel, lamp_grn, fault, fault_code, cam_arm, state_dbg
   );

   modport slave (
      input  id,
      output lamp_red, lamp_yel, lamp_grn, fault, fault_code, cam_arm, state_dbg
   );

endinterface

// File: rtl/tlc_road_decode.sv
// Decodes one road's 3-bit one-hot light code; any non-one-hot value is illegal.
module tlc_road_decode
   import tlc_pkg::*;
(
   input  logic [2:0] code,
   output logic       is_red,
   output logic       is_yel,
   output logic       is_grn,
   output logic       illegal
);

   assign is_red  = (code == RED);
   assign is_yel  = (code == YEL);
   assign is_grn  = (code == GRN);
   assign illegal = !(is_red || is_yel || is_grn);

endmodule

// File: rtl/tlc_lamp_monitor.sv
// Lamp decoder, yellow stretcher and conflict monitor for the 12-bit light code.
// Optional lamp-test input is enabled with the TLC_LAMP_TEST_EN macro.
module tlc_lamp_monitor
   import tlc_pkg::*;
#(
   parameter int YEL_CYC      = 3,
   parameter int CONFLICT_CYC = 2,
   parameter int FLASH_HALF   = 4
) (
   input  logic clock,
   input  logic clear_n,
   tlc_lamp_monitor_if.slave bus
`ifdef TLC_LAMP_TEST_EN
   ,
   input  logic lamp_test
`endif
);

   localparam int YW = (YEL_CYC > 1)      ? $clog2(YEL_CYC)      : 1;
   localparam int CW = (CONFLICT_CYC > 1) ? $clog2(CONFLICT_CYC) : 1;
   localparam int FW = (FLASH_HALF > 1)   ? $clog2(FLASH_HALF)   : 1;

   mon_state_t  state, state_n;
   fault_code_t code_q, code_n;
   logic [11:0] prev_q;
   logic [3:0]  str_mask, str_n;
   logic [YW-1:0] ycnt, ycnt_n;
   logic [CW-1:0] conf_cnt, conf_n, ill_cnt, ill_n;
   logic [FW-1:0] fcnt, fcnt_n;
   logic [3:0]  red_q, yel_q, grn_q, cam_q;
   logic [3:0]  red_n, yel_n, grn_n, cam_n;
   logic        fault_q, fault_n;

   logic [3:0] is_red, is_yel, is_grn, ill, prev_grn;
   logic [3:0] g2y, sel;
   logic       conflict_now, illegal_now, skip_now;
   logic       conf_hit, ill_hit, fault_det;

   // Lamp bit b maps to id[3*b +: 3], so bit3 is road A and bit0 is road D.
   for (genvar b = 0; b < 4; b++) begin : g_road
      tlc_road_decode u_dec (
         .code    (bus.id[3*b +: 3]),
         .is_red  (is_red[b]),
         .is_yel  (is_yel[b]),
         .is_grn  (is_grn[b]),
         .illegal (ill[b])
      );
      assign prev_grn[b] = (prev_q[3*b +: 3] == GRN);
   end

   assign conflict_now = multi_active(is_yel | is_grn);
   assign illegal_now  = |ill;
   assign skip_now     = |(prev_grn & is_red);
   assign g2y          = prev_grn & is_yel;
   assign conf_hit     = conflict_now && (conf_cnt == CW'(CONFLICT_CYC - 1));
   assign ill_hit      = illegal_now  && (ill_cnt  == CW'(CONFLICT_CYC - 1));
   assign fault_det    = conf_hit || ill_hit || skip_now;

   // Road A wins if several roads go green->yellow in the same cycle.
   always_comb begin
      sel = 4'b0000;
      for (int b = 0; b < 4; b++) begin
         if (g2y[b]) sel = 4'b0001 << b;
      end
   end

   always_comb begin
      state_n = state;
      code_n  = code_q;
      fault_n = fault_q;
      str_n   = str_mask;
      ycnt_n  = ycnt;
      conf_n  = conf_cnt;
      ill_n   = ill_cnt;
      fcnt_n  = fcnt;
      red_n   = red_q;
      yel_n   = yel_q;
      grn_n   = grn_q;
      cam_n   = cam_q;
      case (state)
         FLASH: begin
            yel_n = 4'h0;
            grn_n = 4'h0;
            cam_n = 4'h0;
            if (fcnt == FW'(FLASH_HALF - 1)) begin
               fcnt_n = '0;
               red_n  = ~red_q;
            end else begin
               fcnt_n = fcnt + FW'(1);
            end
         end
         default: begin
            conf_n = conflict_now ? conf_cnt + CW'(1) : '0;
            ill_n  = illegal_now  ? ill_cnt  + CW'(1) : '0;
            if (fault_det) begin
               state_n = FLASH;
               fault_n = 1'b1;
               code_n  = conf_hit ? CONFLICT : (ill_hit ? ILLEGAL : SKIP);
               fcnt_n  = '0;
               red_n   = 4'hF;
               yel_n   = 4'h0;
               grn_n   = 4'h0;
               cam_n   = 4'h0;
            end else if (state == STRETCH && ycnt != '0) begin
               ycnt_n = ycnt - YW'(1);
               red_n  = ~str_mask;
               yel_n  = str_mask;
               grn_n  = 4'h0;
               cam_n  = ~str_mask;
            end else if (|g2y) begin
               state_n = STRETCH;
               str_n   = sel;
               ycnt_n  = YW'(YEL_CYC - 1);
               red_n   = ~sel;
               yel_n   = sel;
               grn_n   = 4'h0;
               cam_n   = ~sel;
            end else begin
               // Illegal roads are shown red so a bad code never lights a head.
               state_n = RUN;
               red_n   = is_red | ill;
               yel_n   = is_yel;
               grn_n   = is_grn;
               cam_n   = is_red | ill;
`ifdef TLC_LAMP_TEST_EN
               if (lamp_test && state == RUN && bus.id == ALL_RED) begin
                  red_n = 4'hF;
                  yel_n = 4'hF;
                  grn_n = 4'hF;
                  cam_n = 4'h0;
               end
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state    <= RUN;
         code_q   <= NONE;
         fault_q  <= 1'b0;
         prev_q   <= ALL_RED;
         str_mask <= 4'h0;
         ycnt     <= '0;
         conf_cnt <= '0;
         ill_cnt  <= '0;
         fcnt     <= '0;
         red_q    <= 4'hF;
         yel_q    <= 4'h0;
         grn_q    <= 4'h0;
         cam_q    <= 4'hF;
      end else begin
         state    <= state_n;
         code_q   <= code_n;
         fault_q  <= fault_n;
         prev_q   <= bus.id;
         str_mask <= str_n;
         ycnt     <= ycnt_n;
         conf_cnt <= conf_n;
         ill_cnt  <= ill_n;
         fcnt     <= fcnt_n;
         red_q    <= red_n;
         yel_q    <= yel_n;
         grn_q    <= grn_n;
         cam_q    <= cam_n;
      end
   end

   assign bus.lamp_red   = red_q;
   assign bus.lamp_yel   = yel_q;
   assign bus.lamp_grn   = grn_q;
   assign bus.cam_arm    = cam_q;
   assign bus.fault      = fault_q;
   assign bus.fault_code = code_q;
   assign bus.state_dbg  = state;

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// Directed bench for tlc_lamp_monitor (YEL_CYC=3, CONFLICT_CYC=2, FLASH_HALF=4).
// Define TLC_LAMP_TEST_EN to also exercise the lamp-test input.
module tb_tlc_lamp_monitor;
   import tlc_pkg::*;

   logic clock = 1'b0;
   logic clear_n = 1'b1;
   int   errors = 0;
   int   checks = 0;

   tlc_lamp_monitor_if bus ();

`ifdef TLC_LAMP_TEST_EN
   logic lamp_test = 1'b0;
`endif

   tlc_lamp_monitor #(
      .YEL_CYC      (3),
      .CONFLICT_CYC (2),
      .FLASH_HALF   (4)
   ) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
`ifdef TLC_LAMP_TEST_EN
      ,
      .lamp_test (lamp_test)
`endif
   );

   always #5 clock = ~clock;

   // Apply one code, let one edge sample it, then look 1 time unit later.
   task automatic step(input logic [11:0] v);
      bus.id = v;
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      bus.id  = ALL_RED;
      clear_n = 1'b0;
      @(posedge clock);
      #1;
      clear_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.id = 12'b001100100100;
      #1 clear_n = 1'b0;
      #2;
      checks++; if (bus.lamp_red !== 4'hF) begin errors++; $display("FAIL rst_red got=%h exp=F", bus.lamp_red); end
      checks++; if (bus.lamp_grn !== 4'h0) begin errors++; $display("FAIL rst_grn got=%h exp=0", bus.lamp_grn); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL rst_fault got=%b exp=0", bus.fault); end
      checks++; if (bus.cam_arm !== 4'hF) begin errors++; $display("FAIL rst_cam got=%h exp=F", bus.cam_arm); end
      @(posedge clock);
      #1;
      checks++; if (bus.lamp_red !== 4'hF) begin errors++; $display("FAIL rst_hold_red got=%h exp=F", bus.lamp_red); end
      clear_n = 1'b1;
      step(12'b001100100100);
      checks++; if (bus.lamp_grn !== 4'b1000) begin errors++; $display("FAIL rel_grn got=%b exp=1000", bus.lamp_grn); end
      checks++; if (bus.lamp_red !== 4'b0111) begin errors++; $display("FAIL rel_red got=%b exp=0111", bus.lamp_red); end
      checks++; if (bus.cam_arm !== 4'b0111) begin errors++; $display("FAIL rel_cam got=%b exp=0111", bus.cam_arm); end
   endtask

   task automatic test_stretch();
      apply_reset();
      for (int k = 0; k < 5; k++) step(12'b001100100100);
      step(12'b010100100100);
      checks++; if (bus.lamp_yel !== 4'b1000) begin errors++; $display("FAIL str_entry_yel got=%b exp=1000", bus.lamp_yel); end
      checks++; if (bus.state_dbg !== STRETCH) begin errors++; $display("FAIL str_state got=%0d exp=%0d", bus.state_dbg, STRETCH); end
      for (int k = 0; k < 3; k++) begin
         step(ALL_RED);
         checks++;
         if (bus.lamp_yel !== ((k < 2) ? 4'b1000 : 4'b0000) || bus.lamp_red !== ((k < 2) ? 4'b0111 : 4'hF)) begin
            errors++;
            $display("FAIL str_hold%0d yel=%b red=%b", k, bus.lamp_yel, bus.lamp_red);
         end
      end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL str_fault got=%b exp=0", bus.fault); end
   endtask

   task automatic test_stretch_defer();
      apply_reset();
      for (int k = 0; k < 5; k++) step(12'b001100100100);
      step(12'b010100100100);
      for (int k = 0; k < 3; k++) begin
         step(12'b100100001100);
         checks++;
         if (bus.lamp_grn !== ((k < 2) ? 4'b0000 : 4'b0010) || bus.lamp_yel !== ((k < 2) ? 4'b1000 : 4'b0000)) begin
            errors++;
            $display("FAIL defer%0d grn=%b yel=%b", k, bus.lamp_grn, bus.lamp_yel);
         end
      end
      checks++; if (bus.cam_arm !== 4'b1101) begin errors++; $display("FAIL defer_cam got=%b exp=1101", bus.cam_arm); end
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL defer_fault got=%b exp=0", bus.fault); end
   endtask

   task automatic test_conflict();
      apply_reset();
      // Single-cycle two-way yellows separated by all-red: persistence resets.
      for (int k = 0; k < 4; k++) begin
         step((k % 2 == 0) ? 12'b010010100100 : ALL_RED);
         checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL conf_short%0d fault=%b exp=0", k, bus.fault); end
      end
      step(12'b001001100100);
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL conf_first fault=%b exp=0", bus.fault); end
      step(12'b001001100100);
      checks++; if (bus.fault !== 1'b1) begin errors++; $display("FAIL conf_fault got=%b exp=1", bus.fault); end
      checks++; if (bus.fault_code !== 2'd1) begin errors++; $display("FAIL conf_code got=%0d exp=1", bus.fault_code); end
      checks++; if (bus.lamp_red !== 4'hF || bus.cam_arm !== 4'h0) begin errors++; $display("FAIL conf_flash0 red=%h cam=%h", bus.lamp_red, bus.cam_arm); end
   endtask

   task automatic test_flash();
      logic [11:0] pat [4];
      pat[0] = 12'b001001001001;
      pat[1] = 12'b001100100100;
      pat[2] = 12'b010010010010;
      pat[3] = ALL_RED;
      for (int k = 1; k <= 12; k++) begin
         step(pat[k % 4]);
         checks++;
         if (bus.lamp_red !== (((k / 4) % 2 == 0) ? 4'hF : 4'h0) || bus.lamp_grn !== 4'h0 || bus.lamp_yel !== 4'h0) begin
            errors++;
            $display("FAIL flash%0d red=%h grn=%h yel=%h", k, bus.lamp_red, bus.lamp_grn, bus.lamp_yel);
         end
      end
      checks++; if (bus.fault !== 1'b1 || bus.fault_code !== 2'd1) begin errors++; $display("FAIL flash_latch fault=%b code=%0d exp 1/1", bus.fault, bus.fault_code); end
   endtask

   task automatic test_illegal();
      apply_reset();
      step(12'b100000100100);
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL ill_first fault=%b exp=0", bus.fault); end
      step(12'b100000100100);
      checks++; if (bus.fault_code !== 2'd2) begin errors++; $display("FAIL ill_code got=%0d exp=2", bus.fault_code); end
      apply_reset();
      step(12'b001001000100);
      checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL both_first fault=%b exp=0", bus.fault); end
      step(12'b001001000100);
      checks++; if (bus.fault_code !== 2'd1) begin errors++; $display("FAIL both_code got=%0d exp=1", bus.fault_code); end
   endtask

   task automatic test_skip_recovery();
      apply_reset();
      step(12'b100100100001);
      checks++; if (bus.lamp_grn !== 4'b0001 || bus.fault !== 1'b0) begin errors++; $display("FAIL skip_pre grn=%b fault=%b", bus.lamp_grn, bus.fault); end
      step(ALL_RED);
      checks++; if (bus.fault !== 1'b1 || bus.fault_code !== 2'd3) begin errors++; $display("FAIL skip_code fault=%b code=%0d exp 1/3", bus.fault, bus.fault_code); end
      for (int k = 0; k < 5; k++) step(ALL_RED);
      checks++; if (bus.lamp_red !== 4'h0) begin errors++; $display("FAIL skip_flash_off red=%h exp=0", bus.lamp_red); end
      clear_n = 1'b0;
      #2;
      checks++; if (bus.fault !== 1'b0 || bus.fault_code !== 2'd0) begin errors++; $display("FAIL recov_fault fault=%b code=%0d", bus.fault, bus.fault_code); end
      checks++; if (bus.lamp_red !== 4'hF || bus.cam_arm !== 4'hF) begin errors++; $display("FAIL recov_red red=%h cam=%h", bus.lamp_red, bus.cam_arm); end
      clear_n = 1'b1;
      step(12'b001100100100);
      checks++; if (bus.lamp_grn !== 4'b1000 || bus.fault !== 1'b0) begin errors++; $display("FAIL recov_run grn=%b fault=%b", bus.lamp_grn, bus.fault); end
   endtask

`ifdef TLC_LAMP_TEST_EN
   task automatic test_lamp_test();
      apply_reset();
      lamp_test = 1'b1;
      step(ALL_RED);
      checks++;
      if (bus.lamp_red !== 4'hF || bus.lamp_yel !== 4'hF || bus.lamp_grn !== 4'hF || bus.cam_arm !== 4'h0) begin
         errors++;
         $display("FAIL lamp_test red=%h yel=%h grn=%h cam=%h", bus.lamp_red, bus.lamp_yel, bus.lamp_grn, bus.cam_arm);
      end
      step(12'b001100100100);
      checks++; if (bus.lamp_grn !== 4'b1000) begin errors++; $display("FAIL lamp_test_off grn=%b exp=1000", bus.lamp_grn); end
      lamp_test = 1'b0;
   endtask
`endif

   initial begin
      bus.id = ALL_RED;
      test_reset();
      test_stretch();
      test_stretch_defer();
      test_conflict();
      test_flash();
      test_illegal();
      test_skip_recovery();
`ifdef TLC_LAMP_TEST_EN
      test_lamp_test();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tlc_lamp_monitor.md
Name: tlc_lamp_monitor

Overview:
- Lamp-side consumer of the controller's 12-bit light code bus (ID): decodes per-road codes into lamp drives and enforces a minimum yellow dwell by stretching the controller's one-state yellow.
- Acts as a conflict monitor. On an unsafe code it latches a fault and forces all-way flashing red.
- Sits between the traffic light controller and the signal-head drivers. Also supplies per-road red-phase camera arming.

Parameters:
- YEL_CYC, 3: minimum displayed yellow duration in clock cycles (≥1).
- CONFLICT_CYC, 2: consecutive cycles an unsafe code must persist before a fault latches (≥1).
- FLASH_HALF, 4: half-period of the fault flash, in cycles (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- id  in  12  light code. Road A=[11:9], B=[8:6], C=[5:3], D=[2:0]. 100=red, 010=yellow, 001=green.
- lamp_red  out  4  red lamp drive; bit3=A … bit0=D.
- lamp_yel  out  4  yellow lamp drive, same bit order.
- lamp_grn  out  4  green lamp drive, same bit order.
- fault  out  1  latched fault.
- fault_code  out  2  0=none, 1=conflict, 2=illegal code, 3=skipped yellow.
- cam_arm  out  4  per-road camera arm: displayed red and not flashing.

Behaviour:
- Reset (async, clear_n=0):
  - Outputs: lamp_red=4'hF, lamp_yel=0, lamp_grn=0, fault=0, fault_code=0, cam_arm=4'hF.
  - Internals: prev-code register=12'b100100100100, state=RUN, all counters 0.
- Registering: all outputs are registered. Lamps reflect id sampled at edge N after edge N (1-cycle latency).
- Per-road decode:
  - Valid codes are exactly one-hot 100/010/001. Anything else is illegal.
  - A road is active if green or yellow.
- State RUN:
  - Lamps follow decoded id.
  - On road i: prev=green and id=yellow → enter STRETCH. Latch stretch_road=i, counter=YEL_CYC-1, lamp_yel[i]=1.
- State STRETCH:
  - Road stretch_road shows yellow regardless of id.
  - All other roads show red regardless of id; green requests are deferred, not faulted.
  - Counter decrements each cycle. In the cycle after it reaches 0, state returns to RUN and lamps follow id.
  - A new green→yellow on another road during STRETCH is ignored.
- Conflict check:
  - More than one road active in raw id for CONFLICT_CYC consecutive cycles → fault, code 1.
  - The persistence counter clears on any cycle without the condition.
- Illegal check: any road illegal for CONFLICT_CYC consecutive cycles → fault, code 2.
- Skipped yellow: road with prev=green and id=red in a single cycle → fault, code 3, immediately (no persistence).
- Simultaneous detections: priority conflict > illegal > skip. The first fault's code latches; later faults do not overwrite it.
- Check coverage: checks run in RUN and STRETCH. A fault preempts STRETCH in the same edge.
- State FLASH:
  - Entered on fault.
  - lamp_grn=lamp_yel=0. lamp_red toggles all-4 together every FLASH_HALF cycles, starting ON on the first FLASH cycle.
  - cam_arm=0, fault=1.
  - Exit only via clear_n. id is ignored.
- Reset mid-STRETCH or mid-FLASH returns to the reset values immediately (asynchronous).

Optional Feature:
- Macro: TLC_LAMP_TEST_EN.
- With the macro:
  - Adds input lamp_test (1 bit).
  - When lamp_test=1, state=RUN and id=all-red: all 12 lamp outputs are 1 and cam_arm=0 (1-cycle latency).
  - lamp_test is ignored in STRETCH and FLASH and never affects fault checks.
- Without the macro: the port is absent and the behaviour is as above.

Decomposition:
- Shared package tlc_pkg:
  - Code constants: RED=3'b100, YEL=3'b010, GRN=3'b001, ALL_RED=12'b100100100100.
  - Fault-code constants: NONE/CONFLICT/ILLEGAL/SKIP.
  - Monitor state enum: RUN/STRETCH/FLASH.
- One sub-module, tlc_road_decode:
  - Maps a 3-bit code to is_red/is_yel/is_grn/illegal.
  - Instanced 4× in the top.

Test Plan:
- Reset: assert clear_n=0 with id=001100100100 → lamp_red=4'hF, lamp_grn=0, fault=0, cam_arm=4'hF. Release → lamp_grn=4'b1000 one cycle after the first sampling edge.
- Yellow stretch, with YEL_CYC=3:
  - Stimulus: id=001100100100 ×5 cycles, then 010100100100 ×1, then all-red.
  - Required: lamp_yel=4'b1000 for exactly 3 cycles, then lamp_red=4'hF. No fault.
  - Variant: C requests 100100001100 during the stretch → lamp_grn[1] stays 0 until the stretch ends.
- Conflict: id=001001100100 ×1 cycle, then all-red → no fault. id=001001100100 ×2 cycles → fault=1, fault_code=1.
- Flash: after a fault, lamp_red toggles 4'hF/4'h0 every 4 cycles, and lamp_grn=0 regardless of id.
- Illegal code: road B=3'b000 (id=100000100100) ×2 → fault_code=2. Simultaneous conflict+illegal ×2 → fault_code=1.
- Skipped yellow and reset recovery:
  - id=100100100001 then 100100100100 → fault_code=3 one edge later.
  - Then pulse clear_n low mid-FLASH → fault=0, lamp_red=4'hF, normal RUN resumes.
